usb_data_buffer: RTL and testbench

- 64-byte circular byte FIFO shared between the AHB-Lite slave side and the USB RX/TX packet engines.
- Produces the bufferOccupancy count that the buffer-reservation FSM compares against the TX packet size, or against zero for RX drain.
- AHB side writes and reads 1, 2 or 4 bytes per access; USB side stores and loads one byte per access.

---
 rtl/usb_buffer_pkg.sv | 23 ++
 rtl/usb_buffer_mem.sv | 29 ++
 rtl/usb_data_buffer.sv | 139 +++++++++++++
 tb/tb_usb_data_buffer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/usb_buffer_pkg.sv
// Shared types and helpers for the USB data buffer: transfer size encoding
// and the byte count each encoding stands for.
package usb_buffer_pkg;

  localparam int BUF_DEPTH = 64;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } xfer_size_t;

  // Encoding 3 is not a legal size; zero bytes turns the access into a no-op.
  function automatic logic [2:0] size_to_bytes(input xfer_size_t s);
    case (s)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/usb_buffer_mem.sv
// Byte-wide register file with four write lanes and four read lanes; lane n
// addresses base+n, wrapping modulo DEPTH.
module usb_buffer_mem #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] wr_base_i,
  input  logic [3:0]    wr_en_i,
  input  logic [31:0]   wr_data_i,
  input  logic [AW-1:0] rd_base_i,
  output logic [31:0]   rd_data_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (wr_en_i[l]) begin
        mem_q[wr_base_i + AW'(l)] <= wr_data_i[l*8 +: 8];
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
    assign rd_data_o[gi*8 +: 8] = mem_q[rd_base_i + AW'(gi)];
  end

endmodule

// File: rtl/usb_data_buffer.sv
// Circular byte FIFO between the AHB-Lite slave and the USB RX/TX engines;
// handles arbitration, admission against occupancy, and error pulses.
module usb_data_buffer
  import usb_buffer_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             clear,
  input  logic             ahbWrite,
  input  logic [1:0]       ahbWriteSize,
  input  logic [31:0]      ahbWriteData,
  input  logic             ahbRead,
  input  logic [1:0]       ahbReadSize,
  output logic [31:0]      ahbReadData,
  input  logic             rxStore,
  input  logic [7:0]       rxByte,
  input  logic             txLoad,
  output logic [7:0]       txByte,
  output logic [OCC_W-1:0] bufferOccupancy,
  output logic             full,
  output logic             empty,
  output logic             overflowErr,
  output logic             underflowErr,
  output logic             collisionErr
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = OCC_W + 1;

  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             ovf_q, ovf_d, und_q, und_d, col_q, col_d;

  logic [2:0]  w_n, r_n;
  logic        w_try, r_try, w_ok, r_ok;
  logic [SW-1:0] w_sum;
  logic [3:0]  wr_en;
  logic [31:0] wr_data, mem_rd, rd_masked;

  always_comb begin
    w_n = 3'd0;
    if (ahbWrite) begin
      w_n = size_to_bytes(xfer_size_t'(ahbWriteSize));
    end else if (rxStore) begin
      w_n = 3'd1;
    end
    r_n = 3'd0;
    if (ahbRead) begin
      r_n = size_to_bytes(xfer_size_t'(ahbReadSize));
    end else if (txLoad) begin
      r_n = 3'd1;
    end

    // Both admissions look at the start-of-cycle occupancy, so a byte written
    // this cycle can never satisfy a read in the same cycle.
    w_try = !clear && (w_n != 3'd0);
    r_try = !clear && (r_n != 3'd0);
    w_sum = {1'b0, occ_q} + SW'(w_n);
    w_ok  = w_try && (w_sum <= SW'(DEPTH));
    r_ok  = r_try && (OCC_W'(r_n) <= occ_q);

    wp_d  = wp_q + (w_ok ? AW'(w_n) : AW'(0));
    rp_d  = rp_q + (r_ok ? AW'(r_n) : AW'(0));
    occ_d = occ_q + (w_ok ? OCC_W'(w_n) : OCC_W'(0)) - (r_ok ? OCC_W'(r_n) : OCC_W'(0));
    if (clear) begin
      wp_d  = '0;
      rp_d  = '0;
      occ_d = '0;
    end

    ovf_d = w_try && !w_ok;
    und_d = r_try && !r_ok;
    col_d = !clear && ((ahbWrite && rxStore) || (ahbRead && txLoad));

    rd_data_d = rd_data_q;
    tx_byte_d = tx_byte_q;
    if (r_ok && ahbRead) begin
      rd_data_d = rd_masked;
    end else if (r_ok) begin
      tx_byte_d = mem_rd[7:0];
    end
  end

  assign wr_data = ahbWrite ? ahbWriteData : {24'h0, rxByte};

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wr_en[gi]               = w_ok && (3'(gi) < w_n);
    assign rd_masked[gi*8 +: 8]    = (3'(gi) < r_n) ? mem_rd[gi*8 +: 8] : 8'h00;
  end

  usb_buffer_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk      (clk),
    .wr_base_i(wp_q),
    .wr_en_i  (wr_en),
    .wr_data_i(wr_data),
    .rd_base_i(rp_q),
    .rd_data_o(mem_rd)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      occ_q     <= '0;
      rd_data_q <= '0;
      tx_byte_q <= '0;
      ovf_q     <= 1'b0;
      und_q     <= 1'b0;
      col_q     <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      occ_q     <= occ_d;
      rd_data_q <= rd_data_d;
      tx_byte_q <= tx_byte_d;
      ovf_q     <= ovf_d;
      und_q     <= und_d;
      col_q     <= col_d;
    end
  end

  assign ahbReadData     = rd_data_q;
  assign txByte          = tx_byte_q;
  assign bufferOccupancy = occ_q;
  assign full            = (occ_q == OCC_W'(DEPTH));
  assign empty           = (occ_q == '0);
  assign overflowErr     = ovf_q;
  assign underflowErr    = und_q;
  assign collisionErr    = col_q;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Directed bench for usb_data_buffer: hand-computed occupancy, data and
// error-pulse expectations for each scenario.
module tb_usb_data_buffer;

  logic        clk = 1'b0;
  logic        nRst;
  logic        clear;
  logic        ahbWrite;
  logic [1:0]  ahbWriteSize;
  logic [31:0] ahbWriteData;
  logic        ahbRead;
  logic [1:0]  ahbReadSize;
  logic [31:0] ahbReadData;
  logic        rxStore;
  logic [7:0]  rxByte;
  logic        txLoad;
  logic [7:0]  txByte;
  logic [6:0]  bufferOccupancy;
  logic        full, empty, overflowErr, underflowErr, collisionErr;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  usb_data_buffer dut (
    .clk            (clk),
    .nRst           (nRst),
    .clear          (clear),
    .ahbWrite       (ahbWrite),
    .ahbWriteSize   (ahbWriteSize),
    .ahbWriteData   (ahbWriteData),
    .ahbRead        (ahbRead),
    .ahbReadSize    (ahbReadSize),
    .ahbReadData    (ahbReadData),
    .rxStore        (rxStore),
    .rxByte         (rxByte),
    .txLoad         (txLoad),
    .txByte         (txByte),
    .bufferOccupancy(bufferOccupancy),
    .full           (full),
    .empty          (empty),
    .overflowErr    (overflowErr),
    .underflowErr   (underflowErr),
    .collisionErr   (collisionErr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 0; ahbWrite = 0; ahbRead = 0; rxStore = 0; txLoad = 0;
  endtask

  task automatic ahb_wr(input logic [1:0] sz, input logic [31:0] d);
    ahbWrite = 1; ahbWriteSize = sz; ahbWriteData = d;
    step();
    idle();
  endtask

  task automatic ahb_rd(input logic [1:0] sz);
    ahbRead = 1; ahbReadSize = sz;
    step();
    idle();
  endtask

  task automatic check_errs(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, overflowErr, underflowErr, collisionErr}, {29'd0, exp});
  endtask

  initial begin
    nRst = 0; idle();
    ahbWriteSize = 0; ahbWriteData = 0; ahbReadSize = 0; rxByte = 0;
    #23;
    check("reset_occ", 32'(bufferOccupancy), 0);
    check("reset_empty", 32'(empty), 1);
    check("reset_full", 32'(full), 0);
    check("reset_rdata", ahbReadData, 0);
    check("reset_txbyte", 32'(txByte), 0);
    check_errs("reset_errs", 3'b000);
    nRst = 1;
    step();

    // Single word round trip
    ahb_wr(2'd2, 32'hDDCCBBAA);
    check("wr4_occ", 32'(bufferOccupancy), 4);
    ahb_rd(2'd2);
    check("rd4_data", ahbReadData, 32'hDDCCBBAA);
    check("rd4_occ", 32'(bufferOccupancy), 0);
    check("rd4_empty", 32'(empty), 1);

    // Invalid size is a silent no-op
    ahb_wr(2'd3, 32'h12345678);
    check("bad_size_occ", 32'(bufferOccupancy), 0);
    check_errs("bad_size_errs", 3'b000);

    // Fill to capacity then overflow
    for (int i = 0; i < 16; i++) ahb_wr(2'd2, 32'h1000 + i);
    check("fill_occ", 32'(bufferOccupancy), 64);
    check("fill_full", 32'(full), 1);
    ahb_wr(2'd0, 32'hFF);
    check_errs("ovf_pulse", 3'b100);
    check("ovf_occ", 32'(bufferOccupancy), 64);
    step();
    check_errs("ovf_clears", 3'b000);

    // Clear, then walk pointers to 60 through the USB side
    clear = 1; step(); idle();
    check("clear_occ", 32'(bufferOccupancy), 0);
    for (int i = 0; i < 60; i++) begin
      rxStore = 1; rxByte = 8'(i); step(); idle();
    end
    check("rx60_occ", 32'(bufferOccupancy), 60);
    for (int i = 0; i < 60; i++) begin
      txLoad = 1; step(); idle();
    end
    check("tx60_last", 32'(txByte), 32'h3B);
    check("tx60_occ", 32'(bufferOccupancy), 0);
    ahb_wr(2'd2, 32'h44332211);
    check_errs("wrap_wr_errs", 3'b000);
    ahb_rd(2'd2);
    check("wrap_rd_data", ahbReadData, 32'h44332211);
    check_errs("wrap_rd_errs", 3'b000);

    // Underflowing 2B read alongside an accepted RX store
    rxStore = 1; rxByte = 8'h11; step(); idle();
    check("occ1", 32'(bufferOccupancy), 1);
    ahbRead = 1; ahbReadSize = 2'd1; rxStore = 1; rxByte = 8'h22;
    step(); idle();
    check_errs("und_pulse", 3'b010);
    check("und_occ", 32'(bufferOccupancy), 2);
    check("und_rdata_hold", ahbReadData, 32'h44332211);
    ahb_rd(2'd1);
    check("rd2_data", ahbReadData, 32'h00002211);

    // Write collision: AHB byte wins over RX byte
    ahbWrite = 1; ahbWriteSize = 2'd0; ahbWriteData = 32'h5A; rxStore = 1; rxByte = 8'h77;
    step(); idle();
    check_errs("col_pulse", 3'b001);
    check("col_occ", 32'(bufferOccupancy), 1);
    txLoad = 1; step(); idle();
    check("col_txbyte", 32'(txByte), 32'h5A);
    check("col_occ_after", 32'(bufferOccupancy), 0);

    // Clear overrides a concurrent write
    ahb_wr(2'd2, 32'hA1A2A3A4);
    ahb_wr(2'd2, 32'hB1B2B3B4);
    ahb_wr(2'd1, 32'h0000C1C2);
    check("occ10", 32'(bufferOccupancy), 10);
    clear = 1; ahbWrite = 1; ahbWriteSize = 2'd2; ahbWriteData = 32'hEEEEEEEE;
    step(); idle();
    check("clr_wr_occ", 32'(bufferOccupancy), 0);
    check("clr_wr_empty", 32'(empty), 1);
    check_errs("clr_wr_errs", 3'b000);
    check("clr_rdata_hold", ahbReadData, 32'h00002211);

    // Asynchronous reset mid-stream
    ahb_wr(2'd2, 32'h01020304);
    #2 nRst = 0; #1;
    check("async_rst_occ", 32'(bufferOccupancy), 0);
    check("async_rst_rdata", ahbReadData, 0);
    nRst = 1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
